sel_reservation_station: RTL and testbench

- Collapsing-queue reservation station placed directly upstream of the SEL functional unit.
- Accepts dispatched SEL micro-ops and holds each one until its source operands are captured.
- Captures source values by snooping the CDB (common data bus, 4-bit tag + 8-bit value).
- Issues the oldest ready entry to the FU, one per cycle, when the FU is not stalled.

---
 rtl/sel_rs_pkg.sv | 30 +++
 rtl/sel_rs_picker.sv | 26 ++
 rtl/sel_reservation_station.sv | 129 ++++++++++++
 tb/tb_sel_reservation_station.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_rs_pkg.sv
// sel_rs_pkg: entry layout and CDB wakeup helper shared by the SEL reservation station.
package sel_rs_pkg;

    localparam int TAGW = 4;

    typedef struct packed {
        logic                 valid;
        logic [7:0]           operand;
        logic [1:0][TAGW-1:0] tag;
        logic [1:0]           rdy;
        logic [1:0][7:0]      val;
        logic [7:0]           wbs;
        logic [7:0]           flags;
        logic [TAGW-1:0]      robid;
    } rs_entry_t;

    function automatic rs_entry_t wake(input rs_entry_t e, input logic cdb_valid,
                                       input logic [TAGW-1:0] cdb_id, input logic [7:0] cdb_val);
        rs_entry_t r;
        r = e;
        for (int s = 0; s < 2; s++) begin
            if (e.valid && cdb_valid && !e.rdy[s] && e.tag[s] == cdb_id) begin
                r.rdy[s] = 1'b1;
                r.val[s] = cdb_val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sel_rs_picker.sv
// sel_rs_picker: lowest-index-first priority encoder giving a one-hot grant and its index.
module sel_rs_picker #(
    parameter  int DEPTH = 4,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sel_reservation_station.sv
// sel_reservation_station: collapsing-queue RS for the SEL FU, sources woken from the CDB.
// Define SEL_RS_CDB_FWD_EN to let a same-cycle CDB broadcast satisfy issue readiness.
module sel_reservation_station
    import sel_rs_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [7:0]           disp_operand,
    input  logic [1:0][TAGW-1:0] disp_tag,
    input  logic [1:0]           disp_rdy,
    input  logic [1:0][7:0]      disp_val,
    input  logic [7:0]           disp_wbs,
    input  logic [7:0]           disp_flags,
    input  logic [TAGW-1:0]      disp_robid,
    input  logic                 cdb_valid,
    input  logic [TAGW-1:0]      cdb_id,
    input  logic [7:0]           cdb_val,
    input  logic                 fu_busy,
    output logic                 issue_valid,
    output logic [7:0]           issue_operand,
    output logic [1:0][7:0]      issue_depvals,
    output logic [7:0]           issue_wbs,
    output logic [7:0]           issue_flags,
    output logic [TAGW-1:0]      issue_robid,
    output logic [CW-1:0]        count
);

    rs_entry_t        q   [DEPTH];
    rs_entry_t        nq  [DEPTH];
    rs_entry_t        w   [DEPTH+1];
    rs_entry_t        ent;
    logic [1:0]       fwd [DEPTH];
    logic [1:0]       srdy[DEPTH];
    logic [1:0][7:0]  sval[DEPTH];
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    wpos;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] grant;
    logic [IW-1:0]    idx;
    logic             any_ready;
    logic             issue;
    logic             accept;

    assign disp_ready  = cnt < CW'(DEPTH);
    assign accept      = disp_valid & disp_ready;
    assign issue       = any_ready & ~fu_busy;
    assign issue_valid = issue;
    assign count       = cnt;
    assign wpos        = cnt - CW'(issue);

    // Effective source state seen by issue; forwarding folds in the live CDB.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
`ifdef SEL_RS_CDB_FWD_EN
                fwd[i][s] = cdb_valid && !q[i].rdy[s] && q[i].tag[s] == cdb_id;
`else
                fwd[i][s] = 1'b0;
`endif
                srdy[i][s] = q[i].rdy[s] | fwd[i][s];
                sval[i][s] = fwd[i][s] ? cdb_val : q[i].val[s];
            end
            ready[i] = q[i].valid & (&srdy[i]);
        end
    end

    sel_rs_picker #(.DEPTH(DEPTH)) u_picker (
        .req   (ready),
        .grant (grant),
        .idx   (idx),
        .any   (any_ready)
    );

    always_comb begin
        issue_operand = '0;
        issue_depvals = '0;
        issue_wbs     = '0;
        issue_flags   = '0;
        issue_robid   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && grant[i]) begin
                issue_operand = q[i].operand;
                issue_depvals = sval[i];
                issue_wbs     = q[i].wbs;
                issue_flags   = q[i].flags;
                issue_robid   = q[i].robid;
            end
        end
    end

    // Immediate form pins source 1 ready; the CDB bypass covers a tag broadcast this cycle.
    assign ent = wake(rs_entry_t'{valid:   1'b1,
                                  operand: disp_operand,
                                  tag:     disp_tag,
                                  rdy:     disp_rdy | {disp_flags[1], 1'b0},
                                  val:     disp_val,
                                  wbs:     disp_wbs,
                                  flags:   disp_flags,
                                  robid:   disp_robid},
                      cdb_valid, cdb_id, cdb_val);

    // Wake every entry first, then collapse over the issued slot and append the dispatch.
    always_comb begin
        w[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) w[i] = wake(q[i], cdb_valid, cdb_id, cdb_val);
        for (int i = 0; i < DEPTH; i++) begin
            nq[i] = (issue && IW'(i) >= idx) ? w[i+1] : w[i];
            if (accept && CW'(i) == wpos) nq[i] = ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
            cnt <= '0;
        end else begin
            q   <= nq;
            cnt <= cnt + CW'(accept) - CW'(issue);
        end
    end

endmodule

// File: tb/tb_sel_reservation_station.sv
// tb_sel_reservation_station: directed bench with an issue scoreboard for sel_reservation_station.
// Expectations follow SEL_RS_CDB_FWD_EN when the bench is built with it.
module tb_sel_reservation_station;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            disp_valid = 1'b0;
    logic            disp_ready;
    logic [7:0]      disp_operand = '0;
    logic [1:0][3:0] disp_tag = '0;
    logic [1:0]      disp_rdy = '0;
    logic [1:0][7:0] disp_val = '0;
    logic [7:0]      disp_wbs = '0;
    logic [7:0]      disp_flags = '0;
    logic [3:0]      disp_robid = '0;
    logic            cdb_valid = 1'b0;
    logic [3:0]      cdb_id = '0;
    logic [7:0]      cdb_val = '0;
    logic            fu_busy = 1'b0;
    logic            issue_valid;
    logic [7:0]      issue_operand;
    logic [1:0][7:0] issue_depvals;
    logic [7:0]      issue_wbs;
    logic [7:0]      issue_flags;
    logic [3:0]      issue_robid;
    logic [2:0]      count;

    int tests = 0;
    int fails = 0;
    logic [43:0] sb[$];

    always #5 clk = ~clk;

    sel_reservation_station #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_operand  (disp_operand),
        .disp_tag      (disp_tag),
        .disp_rdy      (disp_rdy),
        .disp_val      (disp_val),
        .disp_wbs      (disp_wbs),
        .disp_flags    (disp_flags),
        .disp_robid    (disp_robid),
        .cdb_valid     (cdb_valid),
        .cdb_id        (cdb_id),
        .cdb_val       (cdb_val),
        .fu_busy       (fu_busy),
        .issue_valid   (issue_valid),
        .issue_operand (issue_operand),
        .issue_depvals (issue_depvals),
        .issue_wbs     (issue_wbs),
        .issue_flags   (issue_flags),
        .issue_robid   (issue_robid),
        .count         (count)
    );

    function automatic logic [43:0] pay(input logic [7:0] op, dv1, dv0, wbs, flg, input logic [3:0] rob);
        return {op, dv1, dv0, wbs, flg, rob};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Any issue seen mid-cycle must match the oldest outstanding expectation.
    task automatic cyc();
        @(negedge clk);
        if (issue_valid === 1'b1) begin
            if (sb.size() == 0) chk("spurious_issue", issue_valid, 0);
            else chk("issue_payload",
                     {issue_operand, issue_depvals, issue_wbs, issue_flags, issue_robid},
                     sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [7:0] op, input logic [3:0] t0, t1, input logic [1:0] r,
                              input logic [7:0] v0, v1, wbs, flg, input logic [3:0] rob);
        disp_valid   = 1'b1;
        disp_operand = op;
        disp_tag[0]  = t0;
        disp_tag[1]  = t1;
        disp_rdy     = r;
        disp_val[0]  = v0;
        disp_val[1]  = v1;
        disp_wbs     = wbs;
        disp_flags   = flg;
        disp_robid   = rob;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
    endtask

    task automatic bcast(input logic [3:0] id, input logic [7:0] v);
        cdb_valid = 1'b1;
        cdb_id    = id;
        cdb_val   = v;
        cyc();
        cdb_valid = 1'b0;
        cyc();
    endtask

    initial begin
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_count", count, 0);
        chk("reset_disp_ready", disp_ready, 1);
        chk("reset_issue_valid", issue_valid, 0);

        // all-ready dispatch issues the next cycle
        drive_disp(8'h11, 4'd0, 4'd0, 2'b11, 8'h22, 8'h33, 8'h44, 8'h01, 4'd1);
        sb.push_back(pay(8'h11, 8'h33, 8'h22, 8'h44, 8'h01, 4'd1));
        cyc();
        idle();
        #1;
        chk("t1_issue_next_cycle", issue_valid, 1);
        chk("t1_count_1", count, 1);
        cyc();
        chk("t1_count_0", count, 0);

        // wakeup latency
        drive_disp(8'h66, 4'd5, 4'd0, 2'b10, 8'h00, 8'h55, 8'h10, 8'h00, 4'd2);
        cyc();
        idle();
        #1;
        chk("t2_wait_src0", issue_valid, 0);
        cdb_valid = 1'b1;
        cdb_id    = 4'd5;
        cdb_val   = 8'hA7;
        sb.push_back(pay(8'h66, 8'h55, 8'hA7, 8'h10, 8'h00, 4'd2));
        #1;
`ifdef SEL_RS_CDB_FWD_EN
        chk("t2_issue_bcast_cycle", issue_valid, 1);
`else
        chk("t2_no_issue_bcast_cycle", issue_valid, 0);
`endif
        cyc();
        cdb_valid = 1'b0;
        #1;
`ifdef SEL_RS_CDB_FWD_EN
        chk("t2_already_issued", issue_valid, 0);
`else
        chk("t2_issue_after_bcast", issue_valid, 1);
`endif
        cyc();
        chk("t2_count_0", count, 0);

        // fill, out-of-order wake, collapse, refused dispatch while full
        for (int k = 0; k < 4; k++) begin
            drive_disp(8'h30 + 8'(k), 4'(8 + k), 4'd0, 2'b10, 8'h00, 8'h40 + 8'(k),
                       8'h20 + 8'(k), 8'h00, 4'(4 + k));
            cyc();
        end
        idle();
        #1;
        chk("t3_full_count", count, 4);
        chk("t3_full_not_ready", disp_ready, 0);
        drive_disp(8'hEE, 4'd0, 4'd0, 2'b11, 8'hEE, 8'hEE, 8'hEE, 8'h00, 4'hF);
        cdb_valid = 1'b1;
        cdb_id    = 4'd10;
        cdb_val   = 8'hC2;
        sb.push_back(pay(8'h32, 8'h42, 8'hC2, 8'h22, 8'h00, 4'd6));
        cyc();
        idle();
        cyc();
        chk("t3_count_after_issue", count, 3);
        chk("t3_ready_after_issue", disp_ready, 1);
        sb.push_back(pay(8'h33, 8'h43, 8'hC3, 8'h23, 8'h00, 4'd7));
        bcast(4'd11, 8'hC3);
        chk("t3_collapsed_issued", count, 2);
        sb.push_back(pay(8'h30, 8'h40, 8'hC0, 8'h20, 8'h00, 4'd4));
        bcast(4'd8, 8'hC0);
        sb.push_back(pay(8'h31, 8'h41, 8'hC1, 8'h21, 8'h00, 4'd5));
        bcast(4'd9, 8'hC1);
        chk("t3_drained", count, 0);

        // stall holds issue; release drains in age order
        fu_busy = 1'b1;
        drive_disp(8'h50, 4'd0, 4'd0, 2'b11, 8'h51, 8'h52, 8'h53, 8'h00, 4'd8);
        sb.push_back(pay(8'h50, 8'h52, 8'h51, 8'h53, 8'h00, 4'd8));
        cyc();
        drive_disp(8'h60, 4'd0, 4'd0, 2'b11, 8'h61, 8'h62, 8'h63, 8'h00, 4'd9);
        sb.push_back(pay(8'h60, 8'h62, 8'h61, 8'h63, 8'h00, 4'd9));
        cyc();
        idle();
        #1;
        chk("t4_busy_no_issue", issue_valid, 0);
        chk("t4_busy_count", count, 2);
        cyc();
        chk("t4_busy_hold", count, 2);
        fu_busy = 1'b0;
        #1;
        chk("t4_release_issue", issue_valid, 1);
        cyc();
        cyc();
        chk("t4_drained", count, 0);

        // immediate form: only source 0 must wake
        drive_disp(8'h70, 4'd3, 4'd12, 2'b00, 8'h00, 8'h77, 8'h71, 8'h02, 4'd10);
        cyc();
        idle();
        #1;
        chk("t5_imm_waiting", issue_valid, 0);
        cyc();
        chk("t5_imm_count", count, 1);
        sb.push_back(pay(8'h70, 8'h77, 8'h5A, 8'h71, 8'h02, 4'd10));
        bcast(4'd3, 8'h5A);
        chk("t5_imm_issued", count, 0);

        // dispatch-cycle CDB bypass
        drive_disp(8'h80, 4'd6, 4'd0, 2'b10, 8'h00, 8'h81, 8'h82, 8'h00, 4'd11);
        cdb_valid = 1'b1;
        cdb_id    = 4'd6;
        cdb_val   = 8'h9C;
        sb.push_back(pay(8'h80, 8'h81, 8'h9C, 8'h82, 8'h00, 4'd11));
        cyc();
        idle();
        #1;
        chk("t5_bypass_issue", issue_valid, 1);
        cyc();
        chk("t5_bypass_count", count, 0);

        // flush drops entries and the same-cycle dispatch
        for (int k = 0; k < 3; k++) begin
            drive_disp(8'h90, 4'(13 + k), 4'd0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 4'(12 + k));
            cyc();
        end
        idle();
        #1;
        chk("t6_pre_flush_count", count, 3);
        flush = 1'b1;
        drive_disp(8'h9F, 4'd0, 4'd0, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 4'd15);
        cyc();
        flush = 1'b0;
        idle();
        #1;
        chk("t6_flush_count", count, 0);
        chk("t6_flush_issue", issue_valid, 0);
        bcast(4'd13, 8'hD5);
        chk("t6_flush_stays_empty", count, 0);

        // reset in the middle of a wakeup
        drive_disp(8'hA0, 4'd13, 4'd0, 2'b10, 8'h00, 8'hA1, 8'hA2, 8'h00, 4'd1);
        cyc();
        idle();
        rst       = 1'b1;
        cdb_valid = 1'b1;
        cdb_id    = 4'd13;
        cdb_val   = 8'hD0;
`ifdef SEL_RS_CDB_FWD_EN
        sb.push_back(pay(8'hA0, 8'hA1, 8'hD0, 8'hA2, 8'h00, 4'd1));
`endif
        cyc();
        rst       = 1'b0;
        cdb_valid = 1'b0;
        #1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_issue", issue_valid, 0);
        bcast(4'd13, 8'hD1);
        chk("t6_rst_stays_empty", count, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
